// File: rtl/bank_spfifo.sv
// FIFO built from BANKS interleaved single-port RAM banks.
// Read/write collisions on the same bank are parked in a per-bank pending slot.

module d1spram #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   parameter int SRAM  = 1,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             ce,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (ce && we) mem[addr] <= wdata;
   end

   // Both variants return read data one cycle after the access.
   if (SRAM != 0) begin : g_macro
      logic [WIDTH-1:0] rdata_q;
      always_ff @(posedge clk) begin
         if (ce && !we) rdata_q <= mem[addr];
      end
      assign rdata = rdata_q;
   end else begin : g_flop
      logic [AW-1:0] addr_q;
      always_ff @(posedge clk) begin
         if (ce && !we) addr_q <= addr;
      end
      assign rdata = mem[addr_q];
   end

endmodule

module bank_spfifo #(
   parameter int WIDTH    = 16,
   parameter int SIZE     = 32,
   parameter int BANKS    = 2,
   parameter int AL_FULL  = 2,
   parameter int AL_EMPTY = 2,
   parameter int SRAM     = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic                   ack,
   output logic [WIDTH-1:0]       rdata,
   output logic                   rvalid,
   output logic                   full,
   output logic                   empty,
   output logic                   al_full,
   output logic                   al_empty,
   output logic [$clog2(SIZE):0]  count
);

   localparam int AW    = $clog2(SIZE);
   localparam int PW    = AW + 1;
   localparam int BW    = $clog2(BANKS);
   localparam int DW    = AW - BW;
   localparam int DEPTH = SIZE / BANKS;

   localparam logic [PW-1:0] FULL_LEVEL = PW'(SIZE);
   localparam logic [PW-1:0] AF_LEVEL   = PW'(SIZE - AL_FULL);
   localparam logic [PW-1:0] AE_LEVEL   = PW'(AL_EMPTY);

   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic             wen, ren;
   logic [BW-1:0]    wbank, rbank;
   logic [DW-1:0]    waddr, raddr;
   logic [WIDTH-1:0] bank_rdata [BANKS];

   logic             vld_p1;
   logic [BW-1:0]    rbank_p1;
   logic             vld_p2;
   logic [WIDTH-1:0] rdata_p2;

   assign count    = wr_ptr - rd_ptr;
   assign full     = (count == FULL_LEVEL);
   assign empty    = (count == '0);
   assign al_full  = (count >= AF_LEVEL);
   assign al_empty = (count <= AE_LEVEL);

   assign wen = push && (!full || pop);
   assign ren = pop && !empty;
   assign ack = wen;

   assign wbank = wr_ptr[BW-1:0];
   assign rbank = rd_ptr[BW-1:0];
   assign waddr = wr_ptr[AW-1:BW];
   assign raddr = rd_ptr[AW-1:BW];

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      logic             rd_hit, wr_hit;
      logic             pend_vld;
      logic [DW-1:0]    pend_addr;
      logic [WIDTH-1:0] pend_data;
      logic             ce, we;
      logic [DW-1:0]    addr;
      logic [WIDTH-1:0] wd;

      assign rd_hit = ren && (rbank == BW'(b));
      assign wr_hit = wen && (wbank == BW'(b));

      // Read has priority; a drain or direct write uses the port otherwise.
      assign ce   = rd_hit || pend_vld || wr_hit;
      assign we   = !rd_hit;
      assign addr = rd_hit ? raddr : (pend_vld ? pend_addr : waddr);
      assign wd   = pend_vld ? pend_data : wdata;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            pend_vld <= 1'b0;
         end else if (rd_hit && wr_hit) begin
            pend_vld <= 1'b1;
         end else if (!rd_hit) begin
            pend_vld <= 1'b0;
         end
      end

      always_ff @(posedge clk) begin
         if (rd_hit && wr_hit) begin
            pend_addr <= waddr;
            pend_data <= wdata;
         end
      end

      d1spram #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH),
         .SRAM  (SRAM)
      ) u_ram (
         .clk   (clk),
         .ce    (ce),
         .we    (we),
         .addr  (addr),
         .wdata (wd),
         .rdata (bank_rdata[b])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         vld_p1   <= 1'b0;
         rbank_p1 <= '0;
         vld_p2   <= 1'b0;
         rdata_p2 <= '0;
      end else begin
         if (wen) wr_ptr <= wr_ptr + PW'(1);
         if (ren) rd_ptr <= rd_ptr + PW'(1);
         // p0 -> p1: bank access issued, remember which bank answers
         vld_p1 <= ren;
         if (ren) rbank_p1 <= rbank;
         // p1 -> p2: capture bank output into the output register
         vld_p2 <= vld_p1;
         if (vld_p1) rdata_p2 <= bank_rdata[rbank_p1];
      end
   end

   assign rvalid = vld_p2;
   assign rdata  = rdata_p2;

endmodule

// File: tb/tb_bank_spfifo.sv
// Self-checking bench for bank_spfifo: reference queue model plus a read scoreboard.

module tb_bank_spfifo;

   localparam int WIDTH = 16;
   localparam int SIZE  = 32;

   logic             clk;
   logic             rst_n;
   logic             push, pop;
   logic [WIDTH-1:0] wdata;
   logic             ack;
   logic [WIDTH-1:0] rdata;
   logic             rvalid, full, empty, al_full, al_empty;
   logic [5:0]       count;

   bank_spfifo #(
      .WIDTH(WIDTH), .SIZE(SIZE), .BANKS(2), .AL_FULL(2), .AL_EMPTY(2), .SRAM(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .wdata(wdata),
      .ack(ack), .rdata(rdata), .rvalid(rvalid), .full(full), .empty(empty),
      .al_full(al_full), .al_empty(al_empty), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [WIDTH-1:0] mq[$];
   logic [WIDTH-1:0] exp_q[$];
   logic             mv1, mv2;

   typedef struct {
      logic             push;
      logic             pop;
      logic [WIDTH-1:0] wdata;
      logic             exp_ack;
      int               exp_count;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      exp_q.delete();
      mv1 = 1'b0;
      mv2 = 1'b0;
   endtask

   // Entered and left on a falling edge.
   task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d,
                       output logic ack_s);
      logic ren_m, wen_m;
      push = p; pop = q; wdata = d;
      #1;
      ren_m = q && (mq.size() > 0);
      wen_m = p && ((mq.size() < SIZE) || q);
      ack_s = ack;
      chk("ack", ack, wen_m);
      @(posedge clk);
      mv2 = mv1;
      mv1 = ren_m;
      if (ren_m) exp_q.push_back(mq.pop_front());
      if (wen_m) mq.push_back(d);
      #1;
      chk("rvalid", rvalid, mv2);
      if (mv2) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_underflow: got rvalid with 0x%0h, expected no read", rdata);
         end else begin
            logic [WIDTH-1:0] e;
            e = exp_q.pop_front();
            if (rdata !== e) begin
               failures++;
               $display("FAIL rdata: got 0x%0h expected 0x%0h at %0t", rdata, e, $time);
            end
         end
      end
      chk("count", int'(count), mq.size());
      chk("full", full, mq.size() == SIZE);
      chk("empty", empty, mq.size() == 0);
      chk("al_full", al_full, mq.size() >= SIZE - 2);
      chk("al_empty", al_empty, mq.size() <= 2);
      @(negedge clk);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_count", int'(count), 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_al_empty", al_empty, 1);
      chk("rst_al_full", al_full, 0);
   endtask

   initial begin
      logic a;
      logic [WIDTH-1:0] d;

      tbl[0] = '{1'b1, 1'b1, 16'hABCD, 1'b1, 1};
      tbl[1] = '{1'b0, 1'b1, 16'h0000, 1'b0, 0};
      tbl[2] = '{1'b0, 1'b0, 16'h0000, 1'b0, 0};
      tbl[3] = '{1'b0, 1'b0, 16'h0000, 1'b0, 0};
      tbl[4] = '{1'b1, 1'b0, 16'h5555, 1'b1, 1};
      tbl[5] = '{1'b1, 1'b0, 16'h6666, 1'b1, 2};
      tbl[6] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1};
      tbl[7] = '{1'b1, 1'b1, 16'h7777, 1'b1, 1};
      tbl[8] = '{1'b0, 1'b1, 16'h0000, 1'b0, 0};
      tbl[9] = '{1'b0, 1'b1, 16'h0000, 1'b0, 0};

      push = 1'b0; pop = 1'b0; wdata = '0; rst_n = 1'b0;
      model_reset();
      #2;
      chk_reset_outputs();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Fill to full, then one rejected push.
      for (int i = 1; i <= SIZE; i++) step(1'b1, 1'b0, WIDTH'(i), a);
      chk("fill_full", full, 1);
      chk("fill_count", int'(count), SIZE);
      step(1'b1, 1'b0, 16'hDEAD, a);
      chk("push_when_full_ack", a, 0);

      // Drain back-to-back.
      for (int i = 0; i < SIZE; i++) step(1'b0, 1'b1, '0, a);
      step(1'b0, 1'b0, '0, a);
      step(1'b0, 1'b0, '0, a);
      chk("drain_empty", empty, 1);

      // Two words resident, then push+pop every cycle (every cycle collides).
      d = 16'h0100;
      step(1'b1, 1'b0, d, a); d++;
      step(1'b1, 1'b0, d, a); d++;
      for (int i = 0; i < 100; i++) begin
         step(1'b1, 1'b1, d, a);
         d++;
      end
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0, a);

      // Full FIFO with simultaneous push+pop.
      d = 16'h2000;
      for (int i = 0; i < SIZE; i++) begin
         step(1'b1, 1'b0, d, a);
         d++;
      end
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 1'b1, d, a);
         d++;
      end
      chk("full_pp_count", int'(count), SIZE);
      for (int i = 0; i < SIZE + 2; i++) step(1'b0, 1'b1, '0, a);

      // Table of short vectors from empty.
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].push, tbl[i].pop, tbl[i].wdata, a);
         chk($sformatf("tbl%0d_ack", i), a, tbl[i].exp_ack);
         chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].exp_count);
      end
      step(1'b0, 1'b0, '0, a);
      step(1'b0, 1'b0, '0, a);

      // Reset with data stored and reads in flight.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0A00 + WIDTH'(i), a);
      step(1'b0, 1'b1, '0, a);
      step(1'b0, 1'b1, '0, a);
      rst_n = 1'b0;
      push = 1'b0; pop = 1'b0;
      #1;
      chk_reset_outputs();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk_reset_outputs();
      rst_n = 1'b1;
      step(1'b1, 1'b0, 16'h1234, a);
      step(1'b0, 1'b1, '0, a);
      step(1'b0, 1'b0, '0, a);
      step(1'b0, 1'b0, '0, a);

      chk("sb_leftover", exp_q.size(), 0);
      chk("model_leftover", mq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bank_spfifo.md
# bank_spfifo

Parametrised FIFO built from BANKS interleaved single-port SRAM banks (each bank does one read or one write per cycle), generalising the two-bank single-port FIFO to any power-of-two bank count. It resolves read/write bank collisions with a per-bank pending-write slot, so push and pop can both be accepted every cycle. It reports occupancy and threshold-based almost flags. It sits between stream producers and consumers wherever a dual-port macro is unavailable.

## Interface

- WIDTH, 16, data width in bits
- SIZE, 32, total depth in entries; power of two, SIZE/BANKS >= 2
- BANKS, 2, number of single-port banks; power of two, >= 2
- AL_FULL, 2, al_full asserts when free entries <= AL_FULL; range 0..SIZE-1
- AL_EMPTY, 2, al_empty asserts when occupancy <= AL_EMPTY; range 0..SIZE-1
- SRAM, 1, passed to each d1spram bank instance (1 = macro, 0 = flop model)
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset, asynchronous assert, active-low
- push  in  1  write request
- pop  in  1  read request
- wdata  in  WIDTH  write data, sampled when ack is high
- ack  out  1  push accepted this cycle (combinational)
- rdata  out  WIDTH  read data, valid when rvalid is high
- rvalid  out  1  rdata carries the word of a pop accepted 2 cycles earlier
- full  out  1  count == SIZE
- empty  out  1  count == 0
- al_full  out  1  count >= SIZE - AL_FULL
- al_empty  out  1  count <= AL_EMPTY
- count  out  clog2(SIZE)+1  current occupancy

## Operation

- Pointers: wr_ptr and rd_ptr are clog2(SIZE)+1 bits wide and wrap modulo 2*SIZE. count = wr_ptr - rd_ptr, modulo 2*SIZE.
- Mapping: entry pointer p goes to bank p mod BANKS, at bank address (p mod SIZE) / BANKS.
- Push acceptance: wen = push && (!full || pop). ack = wen. When wen is high, wr_ptr increments.
- Pop acceptance: ren = pop && !empty. When ren is high, rd_ptr increments and the addressed bank is read.
- Pop while empty is ignored: no pointer change, no rvalid. There is no bypass; a push+pop on an empty FIFO accepts only the push.
- Collision: when wen and ren target the same bank in the same cycle, the read wins.
  - The write data and address go into that bank's pending slot (data, address, valid bit).
  - The pending slot drains into its bank on the next cycle. No read or new write can target that bank on that cycle, because both pointers advance sequentially.
- Pending slots: one per bank. A drain and a new collision on a different bank can happen in the same cycle. At most one slot per bank is ever occupied.
- Read/write ordering: a collision only occurs when count is a nonzero multiple of BANKS. A buffered entry is therefore always committed at least BANKS-1 cycles before it can be read.
- Full with push+pop: both are accepted and count is unchanged. The read returns the old word, and the new word is held in the pending slot, then committed.
- Flags and count come from the registered pointers and update in the cycle after the accepted push/pop.

## Timing

- Reset (async, while rst_n is low):
  - wr_ptr, rd_ptr, pending valid bits, and the read pipeline clear.
  - Outputs: rdata = 0, rvalid = 0, count = 0, empty = 1, full = 0, al_empty = 1, al_full = (AL_FULL >= SIZE ? 1 : 0).
- Reset mid-operation discards in-flight reads and pending writes. SRAM contents are not cleared.
- Read latency: pop accepted in cycle t → bank data in t+1 → rdata registered with rvalid = 1 in t+2.
  - rvalid is a one-cycle pulse per accepted pop.
  - Back-to-back pops give back-to-back rvalid.
  - rdata holds its last value while rvalid = 0.
- Write latency: a word pushed in cycle t is visible to count/empty in t+1. It is readable by a pop in t+1 if it did not collide.
- Throughput: 1 push and 1 pop per cycle sustained, at any occupancy, including full.

## Test plan

- Reset, then push 0x0001..0x0020 (SIZE = 32) with no pops:
  - ack high on all 32 cycles; full rises after the 32nd push.
  - al_full rises when count reaches 30.
  - A 33rd push gets ack = 0 and count stays 32.
- Then pop 32 times back-to-back: rvalid runs for 32 consecutive cycles starting 2 cycles after the first pop, with data 0x0001..0x0020 in order. empty = 1 after the last pop.
- Pre-fill 2 words, then push+pop every cycle for 100 cycles with incrementing data (BANKS = 2; every cycle collides):
  - count stays 2.
  - The output sequence exactly matches the input sequence, with no loss or duplication.
- Full FIFO, simultaneous push+pop for 40 cycles: count stays 32, and the output is the oldest words in order, followed by the newly pushed words.
- Empty FIFO, push 0xABCD and pop together: ack = 1, no rvalid. A pop on the next cycle returns 0xABCD with rvalid 2 cycles later.
- Assert rst_n = 0 with 5 words stored and 2 pops in flight: rvalid drops immediately, count = 0, empty = 1. After release, a push/pop of 0x1234 returns 0x1234.
